icache_refill_axi: RTL and testbench

//  Refill engine on the memory side of the instruction cache miss interface. Accepts a line-fill

---
 rtl/icache_refill_axi.sv | 155 +++++++++++++++
 tb/tb_icache_refill_axi.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_axi.sv
// icache_refill_axi
//
// Purpose:
//   Refill engine on the memory side of the instruction-cache miss path.
//   - Takes one line-fill request at a time.
//   - Issues one AXI4 INCR burst read of BEATS x 32-bit beats.
//   - Packs the returned beats into a LINE_WD-bit line.
//   - Hands the line back to the icache with a single-cycle reload pulse.
//
// Ports:
//   clk, resetn            clock; synchronous active-low reset
//   rd_req, rd_addr        icache miss request (level) and 64-byte aligned line address
//   reload, cacheline_new  one-cycle "line valid" pulse and the assembled line
//   ar*                    AXI read-address channel (fixed ID/len/size/burst)
//   r*                     AXI read-data channel
//   err_sticky             set by any non-OKAY rresp; cleared only by reset
module icache_refill_axi #(
    parameter logic [3:0] AXI_ID  = 4'h0,
    parameter int         BEATS   = 16,
    parameter int         LINE_WD = 512
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               rd_req,
    input  logic [31:0]        rd_addr,
    output logic               reload,
    output logic [LINE_WD-1:0] cacheline_new,
    output logic [3:0]         arid,
    output logic [31:0]        araddr,
    output logic [7:0]         arlen,
    output logic [2:0]         arsize,
    output logic [1:0]         arburst,
    output logic               arvalid,
    input  logic               arready,
    input  logic [31:0]        rdata,
    input  logic [1:0]         rresp,
    input  logic               rlast,
    input  logic               rvalid,
    output logic               rready,
    output logic               err_sticky
);

    localparam int CNT_WD = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        FILL
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         araddr_q, araddr_d;
    logic [CNT_WD-1:0]   beat_cnt_q, beat_cnt_d;
    logic [LINE_WD-1:0]  line_q, line_d;
    logic                err_q, err_d;
    logic                r_hs;

    // The burst shape is fixed: every refill is one full line of 4-byte INCR beats.
    assign arid    = AXI_ID;
    assign arlen   = 8'(BEATS - 1);
    assign arsize  = 3'b010;
    assign arburst = 2'b01;

    assign araddr        = araddr_q;
    assign cacheline_new = line_q;
    assign err_sticky    = err_q;

    assign r_hs = rvalid && rready;

    // State register.
    // Reset is synchronous; a reset mid-burst drops straight back to IDLE.
    // No drain is needed because the AXI slave shares the same reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            araddr_q   <= '0;
            beat_cnt_q <= '0;
            line_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            araddr_q   <= araddr_d;
            beat_cnt_q <= beat_cnt_d;
            line_q     <= line_d;
            err_q      <= err_d;
        end
    end

    // Next-state and datapath update.
    // The burst ends on rlast, not on the beat count, so a short or long burst
    // from a misbehaving slave still terminates. Extra beats wrap the counter
    // and overwrite earlier words.
    always_comb begin
        state_d    = state_q;
        araddr_d   = araddr_q;
        beat_cnt_d = beat_cnt_q;
        line_d     = line_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (rd_req) begin
                    araddr_d   = rd_addr;
                    beat_cnt_d = '0;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                if (arvalid && arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (r_hs) begin
                    for (int i = 0; i < BEATS; i++) begin
                        if (beat_cnt_q == CNT_WD'(i)) begin
                            line_d[32*i +: 32] = rdata;
                        end
                    end
                    beat_cnt_d = beat_cnt_q + CNT_WD'(1);
                    if (rresp != 2'b00) begin
                        err_d = 1'b1;
                    end
                    if (rlast) begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                // The icache still sees a miss during this cycle, so a
                // request seen here is not a new one.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode.
    // The handshake signals are pure state decodes, which keeps arvalid and
    // rready mutually exclusive.
    always_comb begin
        arvalid = 1'b0;
        rready  = 1'b0;
        reload  = 1'b0;
        case (state_q)
            ADDR:    arvalid = 1'b1;
            DATA:    rready  = 1'b1;
            FILL:    reload  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_icache_refill_axi.sv
// tb_icache_refill_axi
//
// Directed bench for icache_refill_axi.
// A small AXI slave model lives in applyStimulus.
// Outputs are observed and inputs driven on the falling edge.
// Expected lines are built by the bench from the beat data pattern.
module tb_icache_refill_axi;

    logic         clk;
    logic         resetn;
    logic         rd_req;
    logic [31:0]  rd_addr;
    logic         reload;
    logic [511:0] cacheline_new;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic         err_sticky;

    int errors = 0;
    int checks = 0;

    int          rl_cyc;
    int          ar_hs;
    int          arv_cyc;
    int          beats;
    bit          proto_ok;
    bit          timed_out;
    logic [31:0] seen_addr;
    logic [7:0]  seen_len;
    int          pulses;

    icache_refill_axi dut (
        .clk           (clk),
        .resetn        (resetn),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .reload        (reload),
        .cacheline_new (cacheline_new),
        .arid          (arid),
        .araddr        (araddr),
        .arlen         (arlen),
        .arsize        (arsize),
        .arburst       (arburst),
        .arvalid       (arvalid),
        .arready       (arready),
        .rdata         (rdata),
        .rresp         (rresp),
        .rlast         (rlast),
        .rvalid        (rvalid),
        .rready        (rready),
        .err_sticky    (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line for a burst whose beat i carries base+i.
    function automatic logic [511:0] exp_line(input logic [31:0] base);
        logic [511:0] l;
        l = '0;
        for (int i = 0; i < 16; i++) begin
            l[32*i +: 32] = base + 32'(i);
        end
        return l;
    endfunction

    task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raises rd_req and plays the AXI slave until one of three things happens:
    //   - reload is seen: returns in the FILL cycle with rd_req still high;
    //   - stop_beats beats have been delivered: returns in DATA;
    //   - the cycle budget runs out.
    // rl_cycle counts cycles with the request-sampling IDLE cycle as cycle 1.
    task automatic applyStimulus(
        input  logic [31:0] addr,
        input  int          ar_wait,
        input  bit          gaps,
        input  bit          drop_req,
        input  logic [31:0] base,
        input  int          err_beat,
        input  int          stop_beats,
        output int          rl_cycle,
        output int          hs_cnt,
        output int          arv_cnt,
        output int          beat_cnt,
        output bit          ok,
        output bit          tmo,
        output logic [31:0] addr_seen,
        output logic [7:0]  len_seen
    );
        int cycle;
        bit phase;
        bit done;
        cycle     = 0;
        phase     = 1'b1;
        done      = 1'b0;
        rl_cycle  = -1;
        hs_cnt    = 0;
        arv_cnt   = 0;
        beat_cnt  = 0;
        ok        = 1'b1;
        tmo       = 1'b0;
        addr_seen = '0;
        len_seen  = '0;
        rd_req    = 1'b1;
        rd_addr   = addr;
        while (!done) begin
            if (reload) begin
                rl_cycle = cycle + 1;
                done     = 1'b1;
            end else if (stop_beats >= 0 && rready && beat_cnt == stop_beats) begin
                rvalid = 1'b0;
                rlast  = 1'b0;
                done   = 1'b1;
            end else begin
                if (arvalid && rready) ok = 1'b0;
                arready = 1'b0;
                if (arvalid) begin
                    if (arv_cnt == 0) begin
                        addr_seen = araddr;
                        len_seen  = arlen;
                    end
                    if (araddr !== addr || arlen !== 8'd15 || arid !== 4'h0 ||
                        arsize !== 3'b010 || arburst !== 2'b01) ok = 1'b0;
                    arv_cnt++;
                    if (arv_cnt > ar_wait) begin
                        arready = 1'b1;
                        hs_cnt++;
                    end
                end
                rvalid = 1'b0;
                rlast  = 1'b0;
                rresp  = 2'b00;
                rdata  = '0;
                if (rready) begin
                    if (drop_req) rd_req = 1'b0;
                    if (!gaps || phase) begin
                        rvalid = 1'b1;
                        rdata  = base + 32'(beat_cnt);
                        rresp  = (beat_cnt == err_beat) ? 2'b10 : 2'b00;
                        rlast  = (beat_cnt == 15);
                        beat_cnt++;
                    end
                    phase = !phase;
                end
                @(negedge clk);
                cycle++;
                if (cycle > 200) begin
                    tmo  = 1'b1;
                    done = 1'b1;
                end
            end
        end
        arready = 1'b0;
    endtask

    initial begin
        resetn  = 1'b0;
        rd_req  = 1'b0;
        rd_addr = '0;
        arready = 1'b0;
        rdata   = '0;
        rresp   = 2'b00;
        rlast   = 1'b0;
        rvalid  = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_arvalid", 512'(arvalid), 512'(1'b0));
        checkOutput("rst_rready", 512'(rready), 512'(1'b0));
        checkOutput("rst_reload", 512'(reload), 512'(1'b0));
        checkOutput("rst_err", 512'(err_sticky), 512'(1'b0));
        checkOutput("rst_araddr", 512'(araddr), 512'(32'h0));
        checkOutput("rst_line", cacheline_new, 512'(0));
        resetn = 1'b1;
        @(negedge clk);

        $display("[TB] zero-wait refill");
        applyStimulus(32'h1FC0_0040, 0, 1'b0, 1'b0, 32'h0, -1, -1,
                      rl_cyc, ar_hs, arv_cyc, beats, proto_ok, timed_out, seen_addr, seen_len);
        checkOutput("t1_timeout", 512'(timed_out), 512'(1'b0));
        checkOutput("t1_araddr", 512'(seen_addr), 512'(32'h1FC0_0040));
        checkOutput("t1_arlen", 512'(seen_len), 512'(8'd15));
        checkOutput("t1_proto", 512'(proto_ok), 512'(1'b1));
        checkOutput("t1_reload_cycle", 512'(rl_cyc), 512'(19));
        checkOutput("t1_beat0", 512'(cacheline_new[31:0]), 512'(32'd0));
        checkOutput("t1_beat15", 512'(cacheline_new[511:480]), 512'(32'd15));
        checkOutput("t1_line", cacheline_new, exp_line(32'h0));
        rd_req = 1'b0;
        @(negedge clk);
        checkOutput("t1_reload_one_cycle", 512'(reload), 512'(1'b0));
        @(negedge clk);
        checkOutput("t1_line_held", cacheline_new, exp_line(32'h0));

        $display("[TB] AR backpressure");
        applyStimulus(32'h0000_1280, 5, 1'b0, 1'b0, 32'h1111_0000, -1, -1,
                      rl_cyc, ar_hs, arv_cyc, beats, proto_ok, timed_out, seen_addr, seen_len);
        checkOutput("t2_timeout", 512'(timed_out), 512'(1'b0));
        checkOutput("t2_arvalid_cycles", 512'(arv_cyc), 512'(6));
        checkOutput("t2_ar_handshakes", 512'(ar_hs), 512'(1));
        checkOutput("t2_proto", 512'(proto_ok), 512'(1'b1));
        checkOutput("t2_reload_cycle", 512'(rl_cyc), 512'(24));
        checkOutput("t2_line", cacheline_new, exp_line(32'h1111_0000));
        rd_req = 1'b0;
        @(negedge clk);

        $display("[TB] R gaps with request dropped mid-burst");
        applyStimulus(32'h8000_0FC0, 0, 1'b1, 1'b1, 32'hCAFE_0100, -1, -1,
                      rl_cyc, ar_hs, arv_cyc, beats, proto_ok, timed_out, seen_addr, seen_len);
        checkOutput("t3_timeout", 512'(timed_out), 512'(1'b0));
        checkOutput("t3_beats", 512'(beats), 512'(16));
        checkOutput("t3_line", cacheline_new, exp_line(32'hCAFE_0100));
        checkOutput("t3_proto", 512'(proto_ok), 512'(1'b1));
        @(negedge clk);
        checkOutput("t3_reload_one_cycle", 512'(reload), 512'(1'b0));

        $display("[TB] back-to-back requests");
        applyStimulus(32'h0000_2000, 0, 1'b0, 1'b0, 32'h2000_0000, -1, -1,
                      rl_cyc, ar_hs, arv_cyc, beats, proto_ok, timed_out, seen_addr, seen_len);
        checkOutput("t4a_timeout", 512'(timed_out), 512'(1'b0));
        checkOutput("t4a_line", cacheline_new, exp_line(32'h2000_0000));
        @(negedge clk);
        checkOutput("t4_no_ar_after_fill", 512'(arvalid), 512'(1'b0));
        checkOutput("t4_reload_drop", 512'(reload), 512'(1'b0));
        applyStimulus(32'h0000_2040, 0, 1'b0, 1'b0, 32'h3000_0000, -1, -1,
                      rl_cyc, ar_hs, arv_cyc, beats, proto_ok, timed_out, seen_addr, seen_len);
        checkOutput("t4b_timeout", 512'(timed_out), 512'(1'b0));
        checkOutput("t4b_araddr", 512'(seen_addr), 512'(32'h0000_2040));
        checkOutput("t4b_ar_handshakes", 512'(ar_hs), 512'(1));
        checkOutput("t4b_reload_cycle", 512'(rl_cyc), 512'(19));
        checkOutput("t4b_line", cacheline_new, exp_line(32'h3000_0000));
        rd_req = 1'b0;
        @(negedge clk);

        $display("[TB] error response on beat 7");
        checkOutput("t5_err_before", 512'(err_sticky), 512'(1'b0));
        applyStimulus(32'h0004_0000, 0, 1'b0, 1'b0, 32'hE000_0000, 7, -1,
                      rl_cyc, ar_hs, arv_cyc, beats, proto_ok, timed_out, seen_addr, seen_len);
        checkOutput("t5_timeout", 512'(timed_out), 512'(1'b0));
        checkOutput("t5_line", cacheline_new, exp_line(32'hE000_0000));
        checkOutput("t5_err_set", 512'(err_sticky), 512'(1'b1));
        rd_req = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("t5_err_sticky", 512'(err_sticky), 512'(1'b1));

        $display("[TB] reset in DATA after beat 4");
        applyStimulus(32'h0000_7700, 0, 1'b0, 1'b0, 32'h6000_0000, -1, 4,
                      rl_cyc, ar_hs, arv_cyc, beats, proto_ok, timed_out, seen_addr, seen_len);
        checkOutput("t6_timeout", 512'(timed_out), 512'(1'b0));
        checkOutput("t6_in_data", 512'(rready), 512'(1'b1));
        resetn = 1'b0;
        rd_req = 1'b0;
        @(negedge clk);
        checkOutput("t6_arvalid", 512'(arvalid), 512'(1'b0));
        checkOutput("t6_rready", 512'(rready), 512'(1'b0));
        checkOutput("t6_reload", 512'(reload), 512'(1'b0));
        checkOutput("t6_err", 512'(err_sticky), 512'(1'b0));
        checkOutput("t6_araddr", 512'(araddr), 512'(32'h0));
        checkOutput("t6_line", cacheline_new, 512'(0));
        resetn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (reload) pulses++;
        end
        checkOutput("t6_no_reload", 512'(pulses), 512'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
